mcu_prog_loader: RTL and testbench
==================================

MCU_PROG_LOADER -- requirements
Module: mcu_prog_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning program-memory address width (matches the 8-bit PC).
REQ-002 The block SHALL have parameter OPC_W, default 4, meaning opcode field width; the instruction word is OPC_W+8 = 12 bits.
REQ-003 clk  input  1  system clock, rising edge active.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 load_req  input  1  single-cycle request to abort the current state and start a new program load.
REQ-006 in_data  input  8  host byte stream.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both high.
REQ-009 pm_we  output  1  program-memory write strobe, one cycle per instruction.
REQ-010 pm_addr  output  ADDR_W  program-memory write address.
REQ-011 pm_wdata  output  12  instruction word: opcode in [11:8], operand in [7:0].
REQ-012 core_rst_n  output  1  active-low reset to the MCU core; low while loading or after an error.
REQ-013 busy, done, err  output  1 each  load status flags.
REQ-014 word_cnt  output  9  number of instructions written in the current load.

Function
REQ-015 The states SHALL be HDR, HI, LO, CHK, DONE and ERR.
REQ-016 HDR: accept byte N as the instruction count (N = 1..255); N = 0 SHALL go to ERR, otherwise go to HI.
REQ-017 HI: accept the opcode byte; bits [7:4] not equal to 0 SHALL go to ERR; otherwise latch bits [3:0] and go to LO.
REQ-018 LO: accept the operand byte; on the next cycle pm_we SHALL be 1 with pm_addr = word_cnt and pm_wdata = {opcode, operand}, and word_cnt SHALL increment. Latency is exactly one cycle from the LO transfer to pm_we.
REQ-019 After the LO transfer, go to HI if word_cnt+1 < N, else go to CHK.
REQ-020 CHK: accept one byte and compare it with the 8-bit running sum (mod 256) of every byte accepted since HDR, header included.
REQ-021 On a CHK match, go to DONE; on a mismatch, go to ERR.
REQ-022 in_ready SHALL be 1 in HDR, HI, LO and CHK, and 0 in DONE and ERR.
REQ-023 in_ready SHALL NOT depend combinationally on in_valid.
REQ-024 At most one byte SHALL be accepted per cycle.
REQ-025 core_rst_n SHALL be 0 in every state except DONE; in DONE it SHALL be 1.
REQ-026 core_rst_n SHALL rise on the first cycle in DONE, which is one cycle after the CHK transfer.
REQ-027 busy SHALL be 1 in HDR through CHK, done SHALL be 1 only in DONE, and err SHALL be 1 only in ERR.
REQ-028 DONE and ERR SHALL be held until load_req; in_valid is ignored in both states.
REQ-029 load_req in any state SHALL go to HDR on the next cycle, clear word_cnt and the checksum, and drive core_rst_n low.
REQ-030 load_req SHALL take priority over a simultaneous byte transfer; that byte is dropped and no pm_we results from it.
REQ-031 pm_addr SHALL never wrap, because N ≤ 255.
REQ-032 pm_we SHALL be 0 in every cycle not covered by REQ-018.

Reset
REQ-033 While rst_n = 0: state = HDR, pm_we = 0, pm_addr = 0, pm_wdata = 0, word_cnt = 0, checksum = 0, core_rst_n = 0, busy = 1, done = 0, err = 0, in_ready = 0.
REQ-034 in_ready SHALL assert on the first clock after rst_n rises.
REQ-035 A reset mid-load SHALL discard the partial load.
REQ-036 Memory contents written before the reset are not erased; they are invalid until a successful load completes.

Structure
REQ-037 Shared package mcu_pkg SHALL hold the loader state enum, OPC_W, ADDR_W and the INSTR_W = 12 constant, shared with the MCU core.
REQ-038 The block SHALL be a single module with no sub-module; the program memory is external.

Verification
REQ-039 The bench SHALL cover:
- Normal load: N = 0x02; words (0x01,0x05), (0x0A,0xFF); checksum 0x11 -> pm_we at addr 0 data 0x105, then at addr 1 data 0xAFF; done = 1; core_rst_n rises one cycle after the checksum byte.
- Checksum error: same stream with checksum 0x12 -> err = 1, core_rst_n stays 0, in_ready = 0.
- Bad header and opcode: N = 0x00 -> ERR. Separately, HI byte 0x15 -> ERR with no pm_we issued.
- Backpressure gaps: in_valid toggled 1/0 every cycle during a 3-word load -> identical writes and addresses to a gap-free load.
- Abort: load_req asserted in the same cycle as the second LO byte -> that byte has no pm_we, the state returns to HDR, and word_cnt = 0.
- Async reset mid-load: rst_n pulsed low between clock edges -> all outputs take their REQ-033 values immediately.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared MCU definitions: program-memory geometry, loader state encoding and
// the per-state status flags that the loader registers on its outputs.
package mcu_pkg;

    localparam int ADDR_W  = 8;
    localparam int OPC_W   = 4;
    localparam int INSTR_W = OPC_W + 8;
    localparam int WCNT_W  = 9;

    typedef enum logic [2:0] {
        LDR_HDR  = 3'd0,
        LDR_HI   = 3'd1,
        LDR_LO   = 3'd2,
        LDR_CHK  = 3'd3,
        LDR_DONE = 3'd4,
        LDR_ERR  = 3'd5
    } ldr_state_t;

    typedef struct packed {
        logic in_ready;
        logic busy;
        logic done;
        logic err;
        logic core_rst_n;
    } ldr_flags_t;

    // While reset is held the loader reports busy but refuses bytes.
    localparam ldr_flags_t LDR_FLAGS_RST = '{
        in_ready:   1'b0,
        busy:       1'b1,
        done:       1'b0,
        err:        1'b0,
        core_rst_n: 1'b0
    };

    function automatic ldr_flags_t ldr_flags(input ldr_state_t s);
        ldr_flags_t f;
        f.in_ready   = (s == LDR_HDR) || (s == LDR_HI) || (s == LDR_LO) || (s == LDR_CHK);
        f.busy       = f.in_ready;
        f.done       = (s == LDR_DONE);
        f.err        = (s == LDR_ERR);
        f.core_rst_n = (s == LDR_DONE);
        return f;
    endfunction

endpackage

// File: rtl/mcu_prog_loader_if.sv
// Host byte stream plus program-memory write port of the program loader.
// "master" is the host/memory side, "slave" is the loader itself.
interface mcu_prog_loader_if #(
    parameter int ADDR_W = mcu_pkg::ADDR_W,
    parameter int OPC_W  = mcu_pkg::OPC_W
);

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;

    logic              pm_we;
    logic [ADDR_W-1:0] pm_addr;
    logic [OPC_W+7:0]  pm_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  pm_we,
        input  pm_addr,
        input  pm_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output pm_we,
        output pm_addr,
        output pm_wdata
    );

endinterface

// File: rtl/mcu_prog_loader.sv
// Streams a length-prefixed, checksummed program from a host byte stream into
// external program memory and holds the MCU core in reset until it is valid.
module mcu_prog_loader #(
    parameter int ADDR_W = mcu_pkg::ADDR_W,
    parameter int OPC_W  = mcu_pkg::OPC_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_req,
    mcu_prog_loader_if.slave           bus,
    output logic                       core_rst_n,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [mcu_pkg::WCNT_W-1:0] word_cnt
);

    mcu_pkg::ldr_state_t         r_state;
    mcu_pkg::ldr_state_t         w_state_next;
    mcu_pkg::ldr_flags_t         r_flags;

    logic [7:0]                  r_count;
    logic [OPC_W-1:0]            r_opcode;
    logic [7:0]                  r_sum;
    logic [mcu_pkg::WCNT_W-1:0]  r_word_cnt;

    logic                        r_pm_we;
    logic [ADDR_W-1:0]           r_pm_addr;
    logic [OPC_W+7:0]            r_pm_wdata;

    logic                        w_xfer;
    logic                        w_hi_bad;
    logic                        w_last_word;

    // in_ready is a registered flag, so the handshake never loops back on in_valid.
    assign w_xfer      = bus.in_valid & r_flags.in_ready;
    assign w_hi_bad    = |bus.in_data[7:OPC_W];
    assign w_last_word = (r_word_cnt + 9'd1) >= {1'b0, r_count};

    always_comb begin
        w_state_next = r_state;
        if (load_req) begin
            w_state_next = mcu_pkg::LDR_HDR;
        end else if (w_xfer) begin
            case (r_state)
                mcu_pkg::LDR_HDR:
                    w_state_next = (bus.in_data == 8'd0) ? mcu_pkg::LDR_ERR : mcu_pkg::LDR_HI;
                mcu_pkg::LDR_HI:
                    w_state_next = w_hi_bad ? mcu_pkg::LDR_ERR : mcu_pkg::LDR_LO;
                mcu_pkg::LDR_LO:
                    w_state_next = w_last_word ? mcu_pkg::LDR_CHK : mcu_pkg::LDR_HI;
                mcu_pkg::LDR_CHK:
                    w_state_next = (bus.in_data == r_sum) ? mcu_pkg::LDR_DONE : mcu_pkg::LDR_ERR;
                default:
                    w_state_next = r_state;
            endcase
        end
    end

    // Status flags are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= mcu_pkg::LDR_HDR;
            r_flags    <= mcu_pkg::LDR_FLAGS_RST;
            r_count    <= '0;
            r_opcode   <= '0;
            r_sum      <= '0;
            r_word_cnt <= '0;
            r_pm_we    <= 1'b0;
            r_pm_addr  <= '0;
            r_pm_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_flags <= mcu_pkg::ldr_flags(w_state_next);
            r_pm_we <= 1'b0;
            if (load_req) begin
                r_word_cnt <= '0;
                r_sum      <= '0;
            end else if (w_xfer) begin
                r_sum <= r_sum + bus.in_data;
                case (r_state)
                    mcu_pkg::LDR_HDR: r_count  <= bus.in_data;
                    mcu_pkg::LDR_HI:  r_opcode <= bus.in_data[OPC_W-1:0];
                    mcu_pkg::LDR_LO: begin
                        r_pm_we    <= 1'b1;
                        r_pm_addr  <= r_word_cnt[ADDR_W-1:0];
                        r_pm_wdata <= {r_opcode, bus.in_data};
                        r_word_cnt <= r_word_cnt + 9'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready = r_flags.in_ready;
    assign bus.pm_we    = r_pm_we;
    assign bus.pm_addr  = r_pm_addr;
    assign bus.pm_wdata = r_pm_wdata;
    assign core_rst_n   = r_flags.core_rst_n;
    assign busy         = r_flags.busy;
    assign done         = r_flags.done;
    assign err          = r_flags.err;
    assign word_cnt     = r_word_cnt;

endmodule

// File: tb/tb_mcu_prog_loader.sv
// Scoreboarded bench for mcu_prog_loader: directed streams plus random loads
// checked against a byte-stream-level reference model.
module tb_mcu_prog_loader;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        int                            addr;
        logic [mcu_pkg::INSTR_W-1:0]   data;
    } wr_t;

    typedef struct {
        int                            addr;
        logic [mcu_pkg::INSTR_W-1:0]   data;
        int                            cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_req;
    logic       core_rst_n;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] word_cnt;

    mcu_prog_loader_if bus ();

    mcu_prog_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_req   (load_req),
        .bus        (bus),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    // Reference model outputs
    wr_t  m_wr[int];
    int   m_used;
    bit   m_done;
    bit   m_err;
    int   m_words;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Parse the stream the way the protocol describes it: count, opcode/operand
    // pairs, then a mod-256 sum of everything before the checksum byte.
    function automatic void model_run(input byte_q_t s);
        int         n;
        logic [7:0] sum;
        logic [7:0] hi;
        logic [7:0] lo;
        m_wr.delete();
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_words = 0;
        n       = int'(s[0]);
        sum     = s[0];
        if (n == 0) begin
            m_err  = 1'b1;
            m_used = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            hi  = s[1 + 2 * i];
            sum = sum + hi;
            if (hi > 8'h0F) begin
                m_err  = 1'b1;
                m_used = 2 + 2 * i;
                return;
            end
            lo  = s[2 + 2 * i];
            sum = sum + lo;
            m_wr[2 + 2 * i] = '{addr: i, data: {hi[3:0], lo}};
            m_words++;
        end
        m_used = 2 + 2 * n;
        if (s[1 + 2 * n] == sum) m_done = 1'b1;
        else                     m_err  = 1'b1;
    endfunction

    // Called on a falling edge; returns on the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b, input bit has_wr, input int addr,
                             input logic [mcu_pkg::INSTR_W-1:0] data, input bit abort);
        int   t = 0;
        exp_t e;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        load_req     = abort;
        while (bus.in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (bus.in_ready !== 1'b1) begin
            check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            load_req     = 1'b0;
            return;
        end
        if (has_wr && !abort) begin
            e.addr = addr;
            e.data = data;
            e.cyc  = cyc + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        load_req     = 1'b0;
    endtask

    task automatic load_req_pulse();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check("hdr_in_ready",   32'(bus.in_ready), 32'd1);
        check("hdr_busy",       32'(busy),         32'd1);
        check("hdr_done",       32'(done),         32'd0);
        check("hdr_err",        32'(err),          32'd0);
        check("hdr_core_rst_n", 32'(core_rst_n),   32'd0);
        check("hdr_word_cnt",   32'(word_cnt),     32'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_pm_we",      32'(bus.pm_we),    32'd0);
        check("rst_pm_addr",    32'(bus.pm_addr),  32'd0);
        check("rst_pm_wdata",   32'(bus.pm_wdata), 32'd0);
        check("rst_word_cnt",   32'(word_cnt),     32'd0);
        check("rst_core_rst_n", 32'(core_rst_n),   32'd0);
        check("rst_busy",       32'(busy),         32'd1);
        check("rst_done",       32'(done),         32'd0);
        check("rst_err",        32'(err),          32'd0);
        check("rst_in_ready",   32'(bus.in_ready), 32'd0);
    endtask

    task automatic run_load(input byte_q_t s, input bit gap);
        wr_t w;
        bit  hw;
        model_run(s);
        for (int i = 0; i < m_used; i++) begin
            hw = (m_wr.exists(i) != 0);
            if (hw) w = m_wr[i];
            else begin
                w.addr = 0;
                w.data = '0;
            end
            if (i == m_used - 1) check("core_rst_n_before_last", 32'(core_rst_n), 32'd0);
            send_byte(s[i], hw, w.addr, w.data, 1'b0);
            if (i == m_used - 1) begin
                check("core_rst_n_after_last", 32'(core_rst_n), 32'(m_done));
                check("done_after_last",       32'(done),       32'(m_done));
            end
            if (gap) @(negedge clk);
        end
        // Bytes offered in DONE/ERR must be ignored.
        bus.in_data  = 8'($urandom);
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        check("end_done",       32'(done),         32'(m_done));
        check("end_err",        32'(err),          32'(m_err));
        check("end_busy",       32'(busy),         32'd0);
        check("end_in_ready",   32'(bus.in_ready), 32'd0);
        check("end_core_rst_n", 32'(core_rst_n),   32'(m_done));
        check("end_word_cnt",   32'(word_cnt),     32'(m_words));
        check("sb_drain",       32'(sb_q.size()),  32'd0);
        $display("load N=%0d bytes=%0d gap=%0d words=%0d done=%0d err=%0d",
                 s[0], m_used, gap, m_words, done, err);
    endtask

    // Monitor: every pm_we must match the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pm_we === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("pm_we_unexpected", 32'(bus.pm_we), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("pm_addr",    32'(bus.pm_addr),  32'(e.addr));
                    check("pm_wdata",   32'(bus.pm_wdata), 32'(e.data));
                    check("pm_latency", 32'(cyc),          32'(e.cyc));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        byte_q_t    s;
        int         n;
        logic [7:0] sum;
        logic [7:0] hi;
        logic [7:0] lo;
        bit         allow_bad;

        rst_n        = 1'b0;
        load_req     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        #1;
        check("in_ready_before_first_clk", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("in_ready_after_first_clk", 32'(bus.in_ready), 32'd1);

        // Normal load, then the same stream with a bad checksum
        s = '{8'h02, 8'h01, 8'h05, 8'h0A, 8'hFF, 8'h11};
        run_load(s, 1'b0);
        load_req_pulse();
        s[5] = 8'h12;
        run_load(s, 1'b0);

        // Zero header, then an opcode byte with a non-zero upper nibble
        load_req_pulse();
        s = '{8'h00};
        run_load(s, 1'b0);
        load_req_pulse();
        s = '{8'h01, 8'h15, 8'h00, 8'h16};
        run_load(s, 1'b0);

        // Three-word load with in_valid toggling, then gap-free
        load_req_pulse();
        s = '{8'h03, 8'h02, 8'h10, 8'h0F, 8'h20, 8'h07, 8'h30, 8'h7B};
        run_load(s, 1'b1);
        load_req_pulse();
        run_load(s, 1'b0);

        // Abort coinciding with the second operand byte
        load_req_pulse();
        send_byte(8'h02, 1'b0, 0, 12'h000, 1'b0);
        send_byte(8'h01, 1'b0, 0, 12'h000, 1'b0);
        send_byte(8'h05, 1'b1, 0, 12'h105, 1'b0);
        send_byte(8'h0A, 1'b0, 0, 12'h000, 1'b0);
        send_byte(8'hFF, 1'b1, 1, 12'hAFF, 1'b1);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_busy",     32'(busy),         32'd1);
        check("abort_word_cnt", 32'(word_cnt),     32'd0);
        check("abort_err",      32'(err),          32'd0);
        $display("abort on second LO byte word_cnt=%0d", word_cnt);
        s = '{8'h02, 8'h01, 8'h05, 8'h0A, 8'hFF, 8'h11};
        run_load(s, 1'b0);

        // Asynchronous reset between clock edges with a write on the bus
        load_req_pulse();
        send_byte(8'h03, 1'b0, 0, 12'h000, 1'b0);
        send_byte(8'h01, 1'b0, 0, 12'h000, 1'b0);
        send_byte(8'h22, 1'b1, 0, 12'h122, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_reset_vals();
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        $display("async reset mid-load word_cnt=%0d", word_cnt);
        s = '{8'h02, 8'h0F, 8'h01, 8'h03, 8'h04, 8'h19};
        run_load(s, 1'b0);

        // Random loads
        for (int it = 0; it < 16; it++) begin
            n         = (it == 3) ? 255 : int'($urandom_range(1, 12));
            allow_bad = (it != 3);
            s.delete();
            s.push_back(8'(n));
            sum = 8'(n);
            for (int w = 0; w < n; w++) begin
                if (allow_bad && $urandom_range(0, 19) == 0) hi = 8'($urandom);
                else                                         hi = {4'h0, 4'($urandom)};
                lo  = 8'($urandom);
                s.push_back(hi);
                s.push_back(lo);
                sum = sum + hi + lo;
            end
            if ($urandom_range(0, 3) == 0) s.push_back(sum + 8'd1);
            else                           s.push_back(sum);
            if (it == 7) s[0] = 8'h00;
            load_req_pulse();
            run_load(s, it[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
